// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares the single-port data memory between the CPU
// core and an IO/debug requester with round-robin arbitration.
// Ports:
//   clock, reset          : rising-edge clock, async active-low reset
//   cpu_req/wr/addr/wdata : CPU request, held until cpu_grant
//   cpu_grant/rvalid      : one-cycle access / read-return pulses
//   cpu_rdata             : last CPU read data, held between reads
//   cpu_stall             : cpu_req & ~cpu_grant, to the control unit
//   io_*                  : same channel for the IO/debug requester
//   mem_en/wr/addr/wdata  : memory access strobe and request fields
//   mem_rdata             : memory data, READ_LATENCY cycles after access
module data_memory_arbiter #(
    parameter int DATA_WIDTH    = 11,
    parameter int ADDRESS_WIDTH = 11,
    parameter int READ_LATENCY  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_wr,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_grant,
    output logic                     cpu_rvalid,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     cpu_stall,
    input  logic                     io_req,
    input  logic                     io_wr,
    input  logic [ADDRESS_WIDTH-1:0] io_addr,
    input  logic [DATA_WIDTH-1:0]    io_wdata,
    output logic                     io_grant,
    output logic                     io_rvalid,
    output logic [DATA_WIDTH-1:0]    io_rdata,
    output logic                     io_stall,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       w_sel;
    logic                       w_sel_io;
    logic                       w_access;
    logic                       w_capture;
    logic                       r_owner_io;
    logic                       r_last_io;
    logic                       r_wr;
    logic [ADDRESS_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [1:0]                 r_cnt;
    logic                       r_cpu_rvalid;
    logic                       r_io_rvalid;
    logic [DATA_WIDTH-1:0]      r_cpu_rdata;
    logic [DATA_WIDTH-1:0]      r_io_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_sel     = 1'b0;
        w_sel_io  = 1'b0;
        w_access  = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cpu_req || io_req) begin
                    w_sel = 1'b1;
                    // On a tie, the side that did not win last time goes.
                    w_sel_io = io_req && (!cpu_req || !r_last_io);
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_access = 1'b1;
                w_next   = r_wr ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 2'd1) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner_io   <= 1'b0;
            r_last_io    <= 1'b1;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_cpu_rvalid <= 1'b0;
            r_io_rvalid  <= 1'b0;
            r_cpu_rdata  <= '0;
            r_io_rdata   <= '0;
        end else begin
            if (w_sel) begin
                r_owner_io <= w_sel_io;
                r_last_io  <= w_sel_io;
                r_wr       <= w_sel_io ? io_wr : cpu_wr;
                r_addr     <= w_sel_io ? io_addr : cpu_addr;
                r_wdata    <= w_sel_io ? io_wdata : cpu_wdata;
            end
            if (w_access && !r_wr) begin
                r_cnt <= LAT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 2'd1;
            end
            r_cpu_rvalid <= w_capture && !r_owner_io;
            r_io_rvalid  <= w_capture && r_owner_io;
            if (w_capture && !r_owner_io) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (w_capture && r_owner_io) begin
                r_io_rdata <= mem_rdata;
            end
        end
    end

    assign cpu_grant  = w_access && !r_owner_io;
    assign io_grant   = w_access && r_owner_io;
    assign cpu_rvalid = r_cpu_rvalid;
    assign io_rvalid  = r_io_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign io_rdata   = r_io_rdata;
    // Gated by reset so every output reads 0 while reset is held.
    assign cpu_stall  = reset && cpu_req && !cpu_grant;
    assign io_stall   = reset && io_req && !io_grant;
    assign mem_en     = w_access;
    assign mem_wr     = w_access && r_wr;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: two arbiter instances (READ_LATENCY 1 and 3)
// sharing one stimulus port; sel picks which one is driven and observed.
`timescale 1ns/1ps
module tb_data_memory_arbiter;
    localparam int DW = 11;
    localparam int AW = 11;
    localparam int OW = 6 + 3 * DW + AW + 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sel = 1'b0;
    always #5 clock = ~clock;

    logic          cpu_req = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          io_req = 1'b0;
    logic          io_wr = 1'b0;
    logic [AW-1:0] io_addr = '0;
    logic [DW-1:0] io_wdata = '0;

    logic [1:0]    cpu_grant_v, cpu_rvalid_v, cpu_stall_v;
    logic [1:0]    io_grant_v, io_rvalid_v, io_stall_v;
    logic [1:0]    mem_en_v, mem_wr_v;
    logic [DW-1:0] cpu_rdata_v [2];
    logic [DW-1:0] io_rdata_v [2];
    logic [AW-1:0] mem_addr_v [2];
    logic [DW-1:0] mem_wdata_v [2];
    logic [OW-1:0] outs_v [2];
    logic [DW-1:0] pipe [1:3];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        data_memory_arbiter #(
            .DATA_WIDTH(DW),
            .ADDRESS_WIDTH(AW),
            .READ_LATENCY(k == 0 ? 1 : 3)
        ) u_dut (
            .clock(clock),
            .reset(reset),
            .cpu_req(cpu_req && (int'(sel) == k)),
            .cpu_wr(cpu_wr),
            .cpu_addr(cpu_addr),
            .cpu_wdata(cpu_wdata),
            .cpu_grant(cpu_grant_v[k]),
            .cpu_rvalid(cpu_rvalid_v[k]),
            .cpu_rdata(cpu_rdata_v[k]),
            .cpu_stall(cpu_stall_v[k]),
            .io_req(io_req && (int'(sel) == k)),
            .io_wr(io_wr),
            .io_addr(io_addr),
            .io_wdata(io_wdata),
            .io_grant(io_grant_v[k]),
            .io_rvalid(io_rvalid_v[k]),
            .io_rdata(io_rdata_v[k]),
            .io_stall(io_stall_v[k]),
            .mem_en(mem_en_v[k]),
            .mem_wr(mem_wr_v[k]),
            .mem_addr(mem_addr_v[k]),
            .mem_wdata(mem_wdata_v[k]),
            .mem_rdata(k == 0 ? pipe[1] : pipe[3])
        );
        assign outs_v[k] = {cpu_grant_v[k], cpu_rvalid_v[k], cpu_stall_v[k],
                            cpu_rdata_v[k], io_grant_v[k], io_rvalid_v[k],
                            io_stall_v[k], io_rdata_v[k], mem_en_v[k],
                            mem_wr_v[k], mem_addr_v[k], mem_wdata_v[k]};
    end

    logic          cpu_grant, cpu_rvalid, cpu_stall;
    logic          io_grant, io_rvalid, io_stall;
    logic          mem_en, mem_wr;
    logic [DW-1:0] cpu_rdata, io_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    assign cpu_grant  = cpu_grant_v[sel];
    assign cpu_rvalid = cpu_rvalid_v[sel];
    assign cpu_stall  = cpu_stall_v[sel];
    assign cpu_rdata  = cpu_rdata_v[sel];
    assign io_grant   = io_grant_v[sel];
    assign io_rvalid  = io_rvalid_v[sel];
    assign io_stall   = io_stall_v[sel];
    assign io_rdata   = io_rdata_v[sel];
    assign mem_en     = mem_en_v[sel];
    assign mem_wr     = mem_wr_v[sel];
    assign mem_addr   = mem_addr_v[sel];
    assign mem_wdata  = mem_wdata_v[sel];

    function automatic logic [DW-1:0] f(input int a);
        return (a == 16) ? 11'h123 : DW'(a * 13 + 7);
    endfunction

    // Memory model: read data appears on pipe[n] n cycles after the
    // access and is garbage in every other cycle.
    logic [DW-1:0] mem [0:2047];
    bit mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int a = 0; a < 2048; a++) mem[a] <= f(a);
            mem_ready <= 1'b1;
        end else if (mem_en && mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
        pipe[1] <= (mem_en && !mem_wr) ? mem[mem_addr] : DW'($urandom);
        pipe[2] <= pipe[1];
        pipe[3] <= pipe[2];
    end

    typedef struct {
        logic          io;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } acc_t;

    typedef struct {
        logic          c_req;
        logic          c_wr;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wd;
        logic          i_req;
        logic          i_wr;
        logic [AW-1:0] i_addr;
        logic [DW-1:0] i_wd;
        logic          first_io;
    } vec_t;

    acc_t          q_acc [$];
    logic [DW-1:0] q_rd_cpu [$];
    logic [DW-1:0] q_rd_io [$];
    logic [DW-1:0] shadow [0:2047];
    logic [DW-1:0] last_cpu = '0;
    logic [DW-1:0] last_io = '0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, want);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got unexpected event, required none", nm);
    endtask

    task automatic push(input logic io, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        acc_t e;
        e.io = io; e.wr = wr; e.addr = addr; e.wd = wd;
        q_acc.push_back(e);
        if (wr) shadow[addr] = wd;
        else if (io) q_rd_io.push_back(shadow[addr]);
        else q_rd_cpu.push_back(shadow[addr]);
    endtask

    function automatic bit busy();
        return q_acc.size() != 0 || q_rd_cpu.size() != 0 || q_rd_io.size() != 0;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic flush();
        q_acc.delete();
        q_rd_cpu.delete();
        q_rd_io.delete();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy() && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) fail({nm, "_timeout"});
        flush();
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        bit cg, ig;
        int n;
        cg = 0; ig = 0; n = 0;
        if (v.c_req && v.i_req && v.first_io) begin
            push(1'b1, v.i_wr, v.i_addr, v.i_wd);
            push(1'b0, v.c_wr, v.c_addr, v.c_wd);
        end else begin
            if (v.c_req) push(1'b0, v.c_wr, v.c_addr, v.c_wd);
            if (v.i_req) push(1'b1, v.i_wr, v.i_addr, v.i_wd);
        end
        cpu_req = v.c_req; cpu_wr = v.c_wr;
        cpu_addr = v.c_addr; cpu_wdata = v.c_wd;
        io_req = v.i_req; io_wr = v.i_wr;
        io_addr = v.i_addr; io_wdata = v.i_wd;
        while ((cpu_req || io_req || busy()) && n < 40) begin
            step();
            n++;
            if (cg) cpu_req = 1'b0;
            if (ig) io_req = 1'b0;
            cg = cg | cpu_grant;
            ig = ig | io_grant;
        end
        if (n >= 40) fail({nm, "_timeout"});
        cpu_req = 1'b0;
        io_req = 1'b0;
        flush();
        check({nm, "_cpu_rdata_hold"}, 64'(cpu_rdata), 64'(last_cpu));
        check({nm, "_io_rdata_hold"}, 64'(io_rdata), 64'(last_io));
    endtask

    // Scoreboard: every memory access and read return is matched against
    // the queue entries pushed when the stimulus was issued.
    acc_t me;
    always @(negedge clock) begin
        if (reset) begin
            if (cpu_grant || io_grant) begin
                check("grant_excl", 64'(cpu_grant & io_grant), 64'(0));
                check("grant_mem_en", 64'(mem_en), 64'(1));
            end
            if (cpu_req) check("cpu_stall", 64'(cpu_stall), 64'(!cpu_grant));
            if (io_req) check("io_stall", 64'(io_stall), 64'(!io_grant));
            if (mem_en) begin
                if (q_acc.size() == 0) begin
                    fail("unexpected_access");
                end else begin
                    me = q_acc.pop_front();
                    check("owner", 64'({io_grant, cpu_grant}), 64'({me.io, !me.io}));
                    check("mem_wr", 64'(mem_wr), 64'(me.wr));
                    check("mem_addr", 64'(mem_addr), 64'(me.addr));
                    if (me.wr) check("mem_wdata", 64'(mem_wdata), 64'(me.wd));
                end
            end
            if (cpu_rvalid) begin
                if (q_rd_cpu.size() == 0) begin
                    fail("unexpected_cpu_rvalid");
                end else begin
                    last_cpu = q_rd_cpu.pop_front();
                    check("cpu_rdata", 64'(cpu_rdata), 64'(last_cpu));
                end
            end
            if (io_rvalid) begin
                if (q_rd_io.size() == 0) begin
                    fail("unexpected_io_rvalid");
                end else begin
                    last_io = q_rd_io.pop_front();
                    check("io_rdata", 64'(io_rdata), 64'(last_io));
                end
            end
        end
    end

    vec_t tbl [8];
    vec_t v;
    logic [3:0] exp_io;
    logic [DW-1:0] want;
    int ng, n;

    initial begin
        for (int a = 0; a < 2048; a++) shadow[a] = f(a);
        tbl[0] = '{1'b1, 1'b0, 11'h040, 11'h000, 1'b1, 1'b1, 11'h041, 11'h155, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 11'h042, 11'h2AA, 1'b1, 1'b0, 11'h041, 11'h000, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 11'h000, 11'h000, 1'b1, 1'b0, 11'h7FF, 11'h000, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 11'h042, 11'h000, 1'b1, 1'b0, 11'h000, 11'h000, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 11'h7FF, 11'h7FF, 1'b0, 1'b0, 11'h000, 11'h000, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 11'h050, 11'h001, 1'b1, 1'b1, 11'h051, 11'h400, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 11'h7FF, 11'h000, 1'b0, 1'b0, 11'h000, 11'h000, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 11'h051, 11'h000, 1'b1, 1'b0, 11'h050, 11'h000, 1'b1};

        // Reset held with random inputs: every output of both instances 0.
        repeat (6) begin
            step();
            sel = 1'($urandom);
            cpu_req = 1'($urandom); cpu_wr = 1'($urandom);
            cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
            io_req = 1'($urandom); io_wr = 1'($urandom);
            io_addr = AW'($urandom); io_wdata = DW'($urandom);
            #2;
            check("t1_rst_outs_rl1", 64'(outs_v[0]), 64'(0));
            check("t1_rst_outs_rl3", 64'(outs_v[1]), 64'(0));
        end
        step();
        sel = 1'b0;
        cpu_req = 1'b0; io_req = 1'b0;
        reset = 1'b1;
        step();
        check("t1_idle_outs", 64'(outs_v[0]), 64'(0));

        // Both held with reads: CPU, IO, CPU, IO.
        push(1'b0, 1'b0, 11'h030, '0);
        push(1'b1, 1'b0, 11'h031, '0);
        push(1'b0, 1'b0, 11'h030, '0);
        push(1'b1, 1'b0, 11'h031, '0);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h030;
        io_req = 1'b1; io_wr = 1'b0; io_addr = 11'h031;
        exp_io = 4'b1010;
        ng = 0;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (ng == 4) break;
            if (cpu_grant || io_grant) begin
                check("t4_order", 64'(io_grant), 64'(exp_io[ng]));
                ng++;
            end
        end
        cpu_req = 1'b0;
        io_req = 1'b0;
        check("t4_grant_count", 64'(ng), 64'(4));
        wait_idle("t4");

        // CPU write, cycle exact.
        push(1'b0, 1'b1, 11'h005, 11'h02A);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h005; cpu_wdata = 11'h02A;
        #1;
        check("t2_c0_stall", 64'(cpu_stall), 64'(1));
        check("t2_c0_mem_en", 64'(mem_en), 64'(0));
        step();
        check("t2_c1_grant", 64'(cpu_grant), 64'(1));
        check("t2_c1_mem", 64'({mem_en, mem_wr, mem_addr, mem_wdata}),
              64'({1'b1, 1'b1, 11'h005, 11'h02A}));
        check("t2_c1_stall", 64'(cpu_stall), 64'(0));
        step();
        cpu_req = 1'b0;
        check("t2_c2_mem_en", 64'(mem_en), 64'(0));
        wait_idle("t2");

        // CPU read, READ_LATENCY 1: rvalid in c3.
        push(1'b0, 1'b0, 11'h010, '0);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h010;
        step();
        check("t3_c1_grant", 64'(cpu_grant), 64'(1));
        step();
        cpu_req = 1'b0;
        check("t3_c2_rvalid", 64'(cpu_rvalid), 64'(0));
        step();
        check("t3_c3_rvalid", 64'({cpu_rvalid, io_rvalid}), 64'(2'b10));
        check("t3_c3_rdata", 64'(cpu_rdata), 64'(11'h123));
        wait_idle("t3");

        for (int i = 0; i < 8; i++) begin
            v = tbl[i];
            run_txn(v, $sformatf("vec%0d", i));
        end

        // Reset during the WAIT of an IO read.
        push(1'b1, 1'b0, 11'h060, '0);
        io_req = 1'b1; io_wr = 1'b0; io_addr = 11'h060;
        step();
        check("t5_grant", 64'(io_grant), 64'(1));
        step();
        io_req = 1'b0;
        reset = 1'b0;
        #1;
        check("t5_rst_outs", 64'(outs_v[0]), 64'(0));
        flush();
        last_io = '0;
        last_cpu = '0;
        step();
        step();
        reset = 1'b1;
        repeat (6) step();
        check("t5_io_rdata", 64'(io_rdata), 64'(0));
        v = '{1'b1, 1'b0, 11'h061, 11'h000, 1'b0, 1'b0, 11'h000, 11'h000, 1'b0};
        run_txn(v, "t5_cpu");

        // READ_LATENCY 3 instance: io read, rvalid in c5.
        sel = 1'b1;
        last_cpu = '0;
        want = shadow[11'h070];
        push(1'b1, 1'b0, 11'h070, '0);
        io_req = 1'b1; io_wr = 1'b0; io_addr = 11'h070;
        #1;
        check("t6_c0_stall", 64'(io_stall), 64'(1));
        step();
        check("t6_c1_grant", 64'(io_grant), 64'(1));
        for (int c = 2; c <= 5; c++) begin
            step();
            io_req = 1'b0;
            check($sformatf("t6_c%0d_rvalid", c), 64'(io_rvalid), 64'(c == 5));
        end
        check("t6_c5_rdata", 64'(io_rdata), 64'(want));
        step();
        step();
        check("t6_hold_rvalid", 64'(io_rvalid), 64'(0));
        check("t6_hold_rdata", 64'(io_rdata), 64'(want));
        wait_idle("t6");
        v = '{1'b1, 1'b1, 11'h073, 11'h3C3, 1'b0, 1'b0, 11'h000, 11'h000, 1'b0};
        run_txn(v, "t6_cpu_wr");
        v = '{1'b0, 1'b0, 11'h000, 11'h000, 1'b1, 1'b0, 11'h072, 11'h000, 1'b0};
        run_txn(v, "t6_io_rd2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
